// File: rtl/ffram_pkg.sv
// Shared constants and helpers for the flip-flop register file.
// Imported by the word register and the register-file top.
package ffram_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Ceiling log2, used at elaboration time to size address ports.
    function automatic int ffram_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ffram_word.sv
// One storage word of the register file: WIDTH flops with sync reset,
// clear-all and load enable (clear has priority over load).
module ffram_word
    import ffram_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    // Next-state selection: clear beats load, otherwise hold.
    always_comb begin
        word_d = word_q;
        if (clr) begin
            word_d = {WIDTH{1'b0}};
        end else if (load) begin
            word_d = d;
        end else begin
            word_d = word_q;
        end
    end

    // Word storage register.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= {WIDTH{1'b0}};
        end else begin
            word_q <= word_d;
        end
    end

    assign q = word_q;

endmodule

// File: rtl/ffram_rf.sv
// DEPTH x WIDTH flip-flop register file with one write port, a clear-all
// command and two independent registered read ports with write/clear bypass.
module ffram_rf
    import ffram_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = ffram_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    input  logic             ren0,
    input  logic [AW-1:0]    raddr0,
    output logic [WIDTH-1:0] dout0,
    output logic             rvalid0,
    input  logic             ren1,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] dout1,
    output logic             rvalid1
);

    logic [WIDTH-1:0] mem_s [DEPTH];
    logic [1:0]       ren_s;
    logic [AW-1:0]    raddr_s [2];

    assign ren_s      = {ren1, ren0};
    assign raddr_s[0] = raddr0;
    assign raddr_s[1] = raddr1;

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        logic load_s;
        assign load_s = wen && (waddr == AW'(w));

        ffram_word #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .load  (load_s),
            .d     (din),
            .q     (mem_s[w])
        );
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [WIDTH-1:0] dout_q;
        logic [WIDTH-1:0] dout_d;
        logic             rvalid_q;
        logic             rvalid_d;

        // Read mux with bypass so a read sees the result of this cycle's clear/write.
        always_comb begin
            dout_d   = dout_q;
            rvalid_d = 1'b0;
            if (ren_s[p]) begin
                rvalid_d = 1'b1;
                if (clr) begin
                    dout_d = {WIDTH{1'b0}};
                end else if (wen && (waddr == raddr_s[p])) begin
                    dout_d = din;
                end else begin
                    dout_d = mem_s[raddr_s[p]];
                end
            end else begin
                dout_d   = dout_q;
                rvalid_d = 1'b0;
            end
        end

        // Registered read data and valid.
        always_ff @(posedge clk) begin
            if (reset) begin
                dout_q   <= {WIDTH{1'b0}};
                rvalid_q <= 1'b0;
            end else begin
                dout_q   <= dout_d;
                rvalid_q <= rvalid_d;
            end
        end
    end

    assign dout0   = g_port[0].dout_q;
    assign rvalid0 = g_port[0].rvalid_q;
    assign dout1   = g_port[1].dout_q;
    assign rvalid1 = g_port[1].rvalid_q;

endmodule

// File: tb/tb_ffram_rf.sv
// Directed self-checking bench for ffram_rf (WIDTH=8, DEPTH=4).
module tb_ffram_rf;

    logic       clk;
    logic       reset;
    logic       wen;
    logic [1:0] waddr;
    logic [7:0] din;
    logic       clr;
    logic       ren0;
    logic [1:0] raddr0;
    logic [7:0] dout0;
    logic       rvalid0;
    logic       ren1;
    logic [1:0] raddr1;
    logic [7:0] dout1;
    logic       rvalid1;

    int tests;
    int fails;

    ffram_rf #(.WIDTH(8), .DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .wen     (wen),
        .waddr   (waddr),
        .din     (din),
        .clr     (clr),
        .ren0    (ren0),
        .raddr0  (raddr0),
        .dout0   (dout0),
        .rvalid0 (rvalid0),
        .ren1    (ren1),
        .raddr1  (raddr1),
        .dout1   (dout1),
        .rvalid1 (rvalid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        reset  = 1'b0;
        wen    = 1'b0;
        waddr  = 2'd0;
        din    = 8'h00;
        clr    = 1'b0;
        ren0   = 1'b0;
        raddr0 = 2'd0;
        ren1   = 1'b0;
        raddr1 = 2'd0;
    endtask

    // Apply the currently driven inputs across one rising edge, then settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        reset = 1'b1; wen = 1'b1; waddr = 2'd2; din = 8'hEE;
        ren0 = 1'b1; ren1 = 1'b1; clr = 1'b0;
        step();
        tests++;
        if (dout0 !== 8'h00 || rvalid0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_port0 dout0=%h rvalid0=%b expected 00/0", dout0, rvalid0);
        end
        tests++;
        if (dout1 !== 8'h00 || rvalid1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_port1 dout1=%h rvalid1=%b expected 00/0", dout1, rvalid1);
        end
    endtask

    task automatic test_first_read();
        @(negedge clk);
        idle();
        ren0 = 1'b1; raddr0 = 2'd2;
        step();
        tests++;
        if (dout0 !== 8'h00 || rvalid0 !== 1'b1) begin
            fails++;
            $display("FAIL first_read dout0=%h rvalid0=%b expected 00/1", dout0, rvalid0);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        idle();
        wen = 1'b1; waddr = 2'd1; din = 8'hA5;
        step();
        tests++;
        if (rvalid0 !== 1'b0) begin
            fails++;
            $display("FAIL write_no_read rvalid0=%b expected 0", rvalid0);
        end
        @(negedge clk);
        idle();
        ren0 = 1'b1; raddr0 = 2'd1;
        step();
        tests++;
        if (dout0 !== 8'hA5 || rvalid0 !== 1'b1) begin
            fails++;
            $display("FAIL write_read dout0=%h rvalid0=%b expected a5/1", dout0, rvalid0);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        wen = 1'b1; waddr = 2'd3; din = 8'h3C;
        ren1 = 1'b1; raddr1 = 2'd3;
        ren0 = 1'b1; raddr0 = 2'd1;
        step();
        tests++;
        if (dout1 !== 8'h3C || rvalid1 !== 1'b1) begin
            fails++;
            $display("FAIL bypass_port1 dout1=%h rvalid1=%b expected 3c/1", dout1, rvalid1);
        end
        tests++;
        if (dout0 !== 8'hA5) begin
            fails++;
            $display("FAIL bypass_other_port dout0=%h expected a5", dout0);
        end
        @(negedge clk);
        idle();
        ren0 = 1'b1; raddr0 = 2'd3;
        step();
        tests++;
        if (dout0 !== 8'h3C) begin
            fails++;
            $display("FAIL bypass_stored dout0=%h expected 3c", dout0);
        end
    endtask

    task automatic test_clear();
        logic [7:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle();
            wen = 1'b1; waddr = 2'(i); din = fill[i];
            step();
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle();
            ren0 = 1'b1; raddr0 = 2'(i);
            ren1 = 1'b1; raddr1 = 2'(3 - i);
            step();
            tests++;
            if (dout0 !== fill[i] || dout1 !== fill[3 - i]) begin
                fails++;
                $display("FAIL fill_read addr=%0d dout0=%h dout1=%h expected %h/%h",
                         i, dout0, dout1, fill[i], fill[3 - i]);
            end
        end
        @(negedge clk);
        idle();
        clr = 1'b1; wen = 1'b1; waddr = 2'd0; din = 8'hFF;
        ren0 = 1'b1; raddr0 = 2'd0; ren1 = 1'b1; raddr1 = 2'd2;
        step();
        tests++;
        if (dout0 !== 8'h00 || dout1 !== 8'h00 || rvalid0 !== 1'b1 || rvalid1 !== 1'b1) begin
            fails++;
            $display("FAIL clear_bypass dout0=%h dout1=%h v=%b%b expected 00/00 11",
                     dout0, dout1, rvalid0, rvalid1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle();
            ren0 = 1'b1; raddr0 = 2'(i);
            step();
            tests++;
            if (dout0 !== 8'h00) begin
                fails++;
                $display("FAIL clear_read addr=%0d dout0=%h expected 00", i, dout0);
            end
        end
    endtask

    task automatic test_dual_hold();
        @(negedge clk);
        idle();
        wen = 1'b1; waddr = 2'd1; din = 8'h5A;
        step();
        @(negedge clk);
        idle();
        ren0 = 1'b1; raddr0 = 2'd1; ren1 = 1'b1; raddr1 = 2'd1;
        step();
        tests++;
        if (dout0 !== 8'h5A || dout1 !== 8'h5A) begin
            fails++;
            $display("FAIL dual_same_addr dout0=%h dout1=%h expected 5a/5a", dout0, dout1);
        end
        @(negedge clk);
        idle();
        ren1 = 1'b1; raddr1 = 2'd0; raddr0 = 2'd0;
        step();
        tests++;
        if (dout0 !== 8'h5A || rvalid0 !== 1'b0) begin
            fails++;
            $display("FAIL hold_port0 dout0=%h rvalid0=%b expected 5a/0", dout0, rvalid0);
        end
        tests++;
        if (dout1 !== 8'h00 || rvalid1 !== 1'b1) begin
            fails++;
            $display("FAIL port1_independent dout1=%h rvalid1=%b expected 00/1", dout1, rvalid1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle();
        wen = 1'b1; waddr = 2'd2; din = 8'h77;
        step();
        @(negedge clk);
        idle();
        reset = 1'b1; wen = 1'b1; waddr = 2'd3; din = 8'h99;
        ren0 = 1'b1; raddr0 = 2'd2;
        step();
        tests++;
        if (dout0 !== 8'h00 || rvalid0 !== 1'b0 || dout1 !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid_outputs dout0=%h rvalid0=%b dout1=%h expected 00/0/00",
                     dout0, rvalid0, dout1);
        end
        @(negedge clk);
        idle();
        ren0 = 1'b1; raddr0 = 2'd2; ren1 = 1'b1; raddr1 = 2'd3;
        step();
        tests++;
        if (dout0 !== 8'h00 || dout1 !== 8'h00 || rvalid0 !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_contents dout0=%h dout1=%h rvalid0=%b expected 00/00/1",
                     dout0, dout1, rvalid0);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle();
        test_reset();
        test_first_read();
        test_write_read();
        test_bypass();
        test_clear();
        test_dual_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ffram_rf.md
FFRAM_RF -- requirements
Module: ffram_rf

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, the data word width in bits (>=1).
REQ-002 SHALL provide parameter DEPTH, default 4, the number of words; power of two, >=2.
REQ-003 SHALL provide derived localparam AW = clog2(DEPTH), the address width.
REQ-004 SHALL use one clock and one synchronous, active-high reset; ports in order below.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 wen  in  1  write enable.
REQ-008 waddr  in  AW  write address.
REQ-009 din  in  WIDTH  write data.
REQ-010 clr  in  1  clear-all command, one cycle.
REQ-011 ren0  in  1  read enable, port 0.
REQ-012 raddr0  in  AW  read address, port 0.
REQ-013 dout0  out  WIDTH  registered read data, port 0.
REQ-014 rvalid0  out  1  dout0 updated this cycle.
REQ-015 ren1, raddr1, dout1, rvalid1 SHALL mirror port 0 for read port 1.

Function
REQ-016 Storage SHALL be DEPTH x WIDTH flip-flops; no inferred memory macros.
REQ-017 wen=1, clr=0 -> mem[waddr] <= din at the rising edge; other words hold.
REQ-018 clr=1 -> every word <= 0 at the rising edge; a same-cycle write is discarded (clr wins).
REQ-019 Read latency SHALL be exactly 1 cycle: renN=1 at edge k -> doutN and rvalidN=1 visible after edge k.
REQ-020 renN=1 -> doutN <= mem[raddrN] (pre-edge contents) unless REQ-021/022 applies.
REQ-021 Write bypass: renN=1, wen=1, clr=0, waddr==raddrN -> doutN <= din (new data).
REQ-022 Clear bypass: renN=1, clr=1 -> doutN <= 0.
REQ-023 renN=0 -> doutN holds its previous value, rvalidN <= 0.
REQ-024 Both ports SHALL operate independently; equal addresses SHALL return identical data.
REQ-025 Every address value is legal (power-of-two DEPTH); no wrap or error logic.

Reset
REQ-026 reset=1 at an edge -> all words 0, dout0=dout1=0, rvalid0=rvalid1=0.
REQ-027 reset SHALL override wen, clr, ren0 and ren1 in the same cycle.
REQ-028 First edge after reset deasserts SHALL behave per REQ-017..024 (no dead cycle).

Structure
REQ-029 Package ffram_pkg SHALL hold the clog2 helper function and default WIDTH/DEPTH constants.
REQ-030 One sub-module ffram_word SHALL implement a WIDTH-bit register with sync reset, clear and load enable; ffram_rf instantiates DEPTH of them.
REQ-031 Read muxes and bypass logic SHALL live in ffram_rf, one generate copy per read port.

Verification (WIDTH=8, DEPTH=4)
REQ-032 Reset, then ren0=1 raddr0=2 -> next cycle dout0=0x00, rvalid0=1.
REQ-033 Write 0xA5 to addr 1, next cycle ren0=1 raddr0=1 -> dout0=0xA5 one cycle later.
REQ-034 Same cycle wen=1 waddr=3 din=0x3C, ren1=1 raddr1=3 -> dout1=0x3C after that edge (bypass).
REQ-035 Fill addr0..3 with 0x11,0x22,0x33,0x44; clr=1 with wen=1 waddr=0 din=0xFF -> all reads then return 0x00.
REQ-036 ren0=1 raddr0=1 and ren1=1 raddr1=1 after writing 0x5A -> dout0=dout1=0x5A; then ren0=0 -> dout0 holds 0x5A, rvalid0=0.
REQ-037 reset=1 asserted mid-sequence with wen=1 ren0=1 -> all words and outputs 0, write not performed.
